// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared types and constants for the Tomasulo ALU reservation station.
//   alu_op_t       4-bit integer ALU opcode encoding
//   DEFAULT_TAG_W  default width of producer/destination (ROB) tags
//   DATA_W         operand / result width
//   rs_entry_t     one reservation-station slot at the default tag width
// -----------------------------------------------------------------------------
package tomasulo_pkg;

  localparam int DEFAULT_TAG_W = 4;
  localparam int DATA_W        = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_t;

  typedef struct packed {
    logic                     valid;
    alu_op_t                  op;
    logic [DEFAULT_TAG_W-1:0] dest_tag;
    logic [DATA_W-1:0]        vj;
    logic [DATA_W-1:0]        vk;
    logic                     qj_valid;
    logic [DEFAULT_TAG_W-1:0] qj;
    logic                     qk_valid;
    logic [DEFAULT_TAG_W-1:0] qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// -----------------------------------------------------------------------------
// rs_select
// Picks one ready reservation-station entry for issue.
//   ready  in   NUM_ENTRIES        per-entry ready flags
//   age    in   NUM_ENTRIES^2      age matrix, row-major; age[i*N+j]=1 means
//                                  entry j is older than entry i
//                                  (only with ALU_RS_OLDEST_FIRST_EN)
//   grant  out  NUM_ENTRIES        one-hot selected entry (zero if none)
//   found  out  1                  some entry was selected
// Build option: ALU_RS_OLDEST_FIRST_EN selects the oldest ready entry;
// otherwise the lowest-index ready entry wins.
// -----------------------------------------------------------------------------
import tomasulo_pkg::*;

module rs_select #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic [NUM_ENTRIES-1:0]             ready,
`ifdef ALU_RS_OLDEST_FIRST_EN
  input  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age,
`endif
  output logic [NUM_ENTRIES-1:0]             grant,
  output logic                               found
);

`ifdef ALU_RS_OLDEST_FIRST_EN
  // An entry wins when no other ready entry is older than it; the age
  // relation is a total order over valid entries, so at most one wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (age[i*NUM_ENTRIES+j] && ready[j]) grant[i] = 1'b0;
      end
    end
  end
`else
  // Fixed priority: the first ready entry from index 0 upward wins.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ready[i] && !seen) begin
        grant[i] = 1'b1;
        seen     = 1'b1;
      end
    end
  end
`endif

  assign found = |grant;

endmodule

// File: rtl/alu_reservation_station.sv
// -----------------------------------------------------------------------------
// alu_reservation_station
// Tomasulo reservation station feeding the integer ALU. Buffers dispatched
// ops, captures operands from the common data bus, and presents one ready op
// per cycle on a valid/ready issue port.
//   clk, rst                      clock, async active-high reset
//   flush                         synchronous squash of all entries
//   dispatch_valid/ready          dispatch handshake (ready = a free slot)
//   dispatch_op/dest_tag          opcode and result tag of the new op
//   dispatch_vj/vk                operand values (used when q*_valid=0)
//   dispatch_qj/qk(_valid)        producer tags of still-pending operands
//   cdb_valid/tag/value           result broadcast
//   issue_valid/ready             issue handshake towards the ALU
//   issue_a/b/op/tag              operands, opcode, destination tag
// Build option: ALU_RS_OLDEST_FIRST_EN adds an age matrix so the oldest
// ready entry issues first; without it the lowest-index ready entry issues.
// -----------------------------------------------------------------------------
import tomasulo_pkg::*;

module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = DEFAULT_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic [3:0]        dispatch_op,
  input  logic [TAG_W-1:0]  dispatch_dest_tag,
  input  logic [31:0]       dispatch_vj,
  input  logic [31:0]       dispatch_vk,
  input  logic              dispatch_qj_valid,
  input  logic              dispatch_qk_valid,
  input  logic [TAG_W-1:0]  dispatch_qj,
  input  logic [TAG_W-1:0]  dispatch_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_value,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [31:0]       issue_a,
  output logic [31:0]       issue_b,
  output logic [3:0]        issue_op,
  output logic [TAG_W-1:0]  issue_tag
);

  logic                  valid_q    [NUM_ENTRIES];
  alu_op_t               op_q       [NUM_ENTRIES];
  logic [TAG_W-1:0]      dest_q     [NUM_ENTRIES];
  logic [DATA_W-1:0]     vj_q       [NUM_ENTRIES];
  logic [DATA_W-1:0]     vk_q       [NUM_ENTRIES];
  logic                  qj_valid_q [NUM_ENTRIES];
  logic [TAG_W-1:0]      qj_q       [NUM_ENTRIES];
  logic                  qk_valid_q [NUM_ENTRIES];
  logic [TAG_W-1:0]      qk_q       [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic [NUM_ENTRIES-1:0] alloc;
  logic [NUM_ENTRIES-1:0] grant;
  logic [NUM_ENTRIES-1:0] freed;
  logic                   found;
  logic                   dispatch_fire;
  logic                   issue_fire;
  logic                   bypass_j;
  logic                   bypass_k;
  logic [DATA_W-1:0]      new_vj;
  logic [DATA_W-1:0]      new_vk;

  // Flatten slot status and pick the lowest-index free slot for dispatch.
  // Only registered state is used, so a slot freed by issue this cycle is
  // not visible as free until the next cycle.
  always_comb begin
    logic taken;
    taken = 1'b0;
    alloc = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = valid_q[i];
      ready_vec[i] = valid_q[i] && !qj_valid_q[i] && !qk_valid_q[i];
      if (!valid_q[i] && !taken) begin
        alloc[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  assign dispatch_ready = ~&valid_vec;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign issue_valid    = found && !flush;
  assign issue_fire     = issue_valid && issue_ready;
  assign freed          = issue_fire ? grant : '0;

  // A pending operand whose producer broadcasts in the dispatch cycle is
  // captured directly, otherwise it would miss the broadcast entirely.
  assign bypass_j = dispatch_qj_valid && cdb_valid && (cdb_tag == dispatch_qj);
  assign bypass_k = dispatch_qk_valid && cdb_valid && (cdb_tag == dispatch_qk);
  assign new_vj   = bypass_j ? cdb_value : dispatch_vj;
  assign new_vk   = bypass_k ? cdb_value : dispatch_vk;

`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [NUM_ENTRIES-1:0]             age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]             age_d [NUM_ENTRIES];
  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age_flat;

  // A new entry is younger than everything valid now; a freed entry stops
  // being older than anyone. The column clear wins over the row set.
  always_comb begin
    for (int r = 0; r < NUM_ENTRIES; r++) begin
      age_d[r] = age_q[r];
      if (dispatch_fire && alloc[r]) age_d[r] = valid_vec;
      age_d[r] = age_d[r] & ~freed;
      age_flat[r*NUM_ENTRIES +: NUM_ENTRIES] = age_q[r];
    end
  end

  // Age matrix register; emptied together with the slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ENTRIES; r++) age_q[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_ENTRIES; r++) age_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_ENTRIES; r++) age_q[r] <= age_d[r];
    end
  end

  rs_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_select (
    .ready (ready_vec),
    .age   (age_flat),
    .grant (grant),
    .found (found)
  );
`else
  rs_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_select (
    .ready (ready_vec),
    .grant (grant),
    .found (found)
  );
`endif

  // Slot storage. Flush outranks everything else; otherwise issue frees the
  // granted slot, the CDB wakes matching pending operands of valid slots,
  // and dispatch fills the chosen free slot (never the same slot as issue).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i]    <= 1'b0;
        op_q[i]       <= ALU_ADD;
        dest_q[i]     <= '0;
        vj_q[i]       <= '0;
        vk_q[i]       <= '0;
        qj_valid_q[i] <= 1'b0;
        qj_q[i]       <= '0;
        qk_valid_q[i] <= 1'b0;
        qk_q[i]       <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) valid_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (freed[i]) valid_q[i] <= 1'b0;
        if (valid_q[i] && cdb_valid) begin
          if (qj_valid_q[i] && (qj_q[i] == cdb_tag)) begin
            vj_q[i]       <= cdb_value;
            qj_valid_q[i] <= 1'b0;
          end
          if (qk_valid_q[i] && (qk_q[i] == cdb_tag)) begin
            vk_q[i]       <= cdb_value;
            qk_valid_q[i] <= 1'b0;
          end
        end
        if (dispatch_fire && alloc[i]) begin
          valid_q[i]    <= 1'b1;
          op_q[i]       <= alu_op_t'(dispatch_op);
          dest_q[i]     <= dispatch_dest_tag;
          vj_q[i]       <= new_vj;
          vk_q[i]       <= new_vk;
          qj_valid_q[i] <= dispatch_qj_valid && !bypass_j;
          qj_q[i]       <= dispatch_qj;
          qk_valid_q[i] <= dispatch_qk_valid && !bypass_k;
          qk_q[i]       <= dispatch_qk;
        end
      end
    end
  end

  // Issue payload mux; all zero whenever nothing is presented.
  always_comb begin
    issue_a   = '0;
    issue_b   = '0;
    issue_op  = '0;
    issue_tag = '0;
    if (issue_valid) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (grant[i]) begin
          issue_a   = vj_q[i];
          issue_b   = vk_q[i];
          issue_op  = op_q[i];
          issue_tag = dest_q[i];
        end
      end
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Tomasulo reservation station directly upstream of the integer ALU.
- Buffers dispatched ALU ops until both source operands are available.
- Captures operands broadcast on the common data bus (CDB).
- Presents one ready op per cycle on a valid/ready issue port that drives the ALU's a, b and op inputs.

Parameters:
- NUM_ENTRIES, 4, number of station slots (≥2).
- TAG_W, 4, width of producer/destination tags (ROB index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- dispatch_valid  in  1  new op offered.
- dispatch_ready  out  1  at least one free entry.
- dispatch_op  in  4  ALU opcode (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SLT=0111).
- dispatch_dest_tag  in  TAG_W  tag of the result this op produces.
- dispatch_vj, dispatch_vk  in  32 each  operand values, meaningful when the matching q*_valid=0.
- dispatch_qj_valid, dispatch_qk_valid  in  1 each  operand still pending.
- dispatch_qj, dispatch_qk  in  TAG_W each  producer tags of pending operands.
- cdb_valid  in  1  result broadcast this cycle.
- cdb_tag  in  TAG_W  producer tag of the broadcast.
- cdb_value  in  32  broadcast data.
- issue_valid  out  1  a ready op is presented.
- issue_ready  in  1  ALU stage accepts.
- issue_a, issue_b  out  32 each  operands to ALU a/b.
- issue_op  out  4  opcode to ALU op.
- issue_tag  out  TAG_W  destination tag, forwarded alongside the result.

Behaviour:
- Entry state: valid, op, dest_tag, vj, vk, qj_valid, qj, qk_valid, qk.
- Reset (async): all entries invalid → issue_valid=0, issue_a/b/op/tag=0, dispatch_ready=1.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready && !flush.
  - Writes the lowest-index free entry.
  - dispatch_ready is computed from the current registered state only; an entry freed by issue this cycle is not reusable until the next cycle.
- Wakeup: when cdb_valid=1, every valid entry with qj_valid && qj==cdb_tag loads vj=cdb_value and clears qj_valid; same rule for k. Both operands can wake on one broadcast.
- Same-cycle bypass: an accepted dispatch whose pending tag equals cdb_tag while cdb_valid=1 is written with the CDB value and q*_valid=0.
- Ready entry: valid && !qj_valid && !qk_valid.
- Issue:
  - Combinational from registered state: selects the lowest-index ready entry.
  - issue_valid=1 whenever a ready entry exists and flush=0.
  - issue_a/b/op/tag are zero when issue_valid=0.
  - On issue_valid && issue_ready, the selected entry is invalidated at the edge.
- Latency: an op dispatched with both operands ready (or bypassed) in cycle N has issue_valid in cycle N+1. A CDB wakeup in cycle N also makes the entry eligible in N+1.
- Backpressure: while issue_ready=0, the selection and outputs stay stable. A lower-index entry becoming ready may change the selection; the ALU stage does not rely on stickiness.
- Flush: at the edge, all entries are invalidated. Flush has priority over dispatch, issue and wakeup. issue_valid is forced to 0 in the flush cycle.
- Full: dispatch_ready=0; dispatch_valid is ignored.
- Empty: issue_valid=0.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: ALU_RS_OLDEST_FIRST_EN.
- Defined: issue selects the oldest ready entry using an NUM_ENTRIES×NUM_ENTRIES age matrix.
  - Row set on dispatch; the column is cleared when the entry is freed.
  - Cleared on flush/reset.
- Undefined: lowest-index ready selection; no age state is synthesized.

Decomposition:
- tomasulo_pkg:
  - alu_op_t enum (ALU_ADD…ALU_SLT, 4-bit values as above).
  - TAG_W default constant.
  - rs_entry_t packed struct.
- Sub-module rs_select: takes the ready vector (plus the age matrix when enabled) and returns a one-hot grant and found flag.

Test Plan:
- Basic issue: dispatch ADD vj=10 vk=20 ready, tag=3, issue_ready=1 → next cycle issue_valid=1, a=10, b=20, op=0000, tag=3; following cycle issue_valid=0.
- CDB wakeup: dispatch SUB qj pending on tag 2, vk=30, tag=5; two cycles later cdb tag=2 value=50 → issue_valid the cycle after, a=50, b=30, op=0001.
- Same-cycle bypass: dispatch XOR qk pending on tag 7 with cdb_valid tag=7 value=32'h0F, vj=32'hFF → next cycle issue_valid, b=32'h0F.
- Full and ordering: fill 4 entries pending on tags 1..4 → dispatch_ready=0. CDB tag 3 → entry 2 issues next cycle; dispatch_ready=1 the cycle after the handshake. With oldest-first enabled, the older of two simultaneously woken entries issues first.
- Backpressure: ready SLT entry with issue_ready=0 for 5 cycles → outputs stable, entry retained. issue_ready=1 → single handshake, entry freed.
- Flush and reset: 3 valid entries, assert flush one cycle → issue_valid=0 that cycle and after, dispatch_ready=1. Repeat using rst pulse mid-cycle → outputs clear immediately.
